pad_bank_sync_filter: RTL and testbench

- Parametrised bank of NUM_PADS bidirectional FPGA pads.
- Per pad: one Xilinx IOBUF with a compile-time pull selection, a SYNC_STAGES-deep input synchroniser, a programmable-threshold glitch filter, and single-cycle rise/fall event pulses.
- Sits between the pad frame and the peripheral mux (GPIO, UART, I2C).
- Replaces per-signal bare IOBUF wrappers where inputs are asynchronous to clk_i.

---
 rtl/pad_bank_sync_filter.sv | 113 +++++++++++
 tb/tb_pad_bank_sync_filter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bank_sync_filter.sv
// Bank of bidirectional pads: tristate pad buffer, input synchroniser,
// programmable glitch filter and single-cycle rise/fall event pulses.
module pad_bank_sync_filter #(
    parameter int unsigned          NUM_PADS      = 8,
    parameter int unsigned          SYNC_STAGES   = 2,
    parameter int unsigned          FILT_W        = 4,
    parameter logic [NUM_PADS-1:0]  PULLUP_MASK   = '0,
    parameter logic [NUM_PADS-1:0]  PULLDOWN_MASK = '0,
    parameter logic [NUM_PADS-1:0]  IN_RESET_VAL  = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_PADS-1:0] pad_oen_i,
    input  logic [NUM_PADS-1:0] pad_out_i,
    input  logic [NUM_PADS-1:0] filt_en_i,
    input  logic [FILT_W-1:0]   filt_thresh_i,
    output logic [NUM_PADS-1:0] pad_in_raw_o,
    output logic [NUM_PADS-1:0] pad_in_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    inout  wire  [NUM_PADS-1:0] pad_io
);

    if ((PULLUP_MASK & PULLDOWN_MASK) != '0) begin : g_bad_pull
        $error("pad_bank_sync_filter: pad has both PULLUP and PULLDOWN");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pad_bank_sync_filter: SYNC_STAGES must be 2..4");
    end

    logic [NUM_PADS-1:0] pad_in_w;

    // IOBUF equivalent: T=1 releases the pin, O always follows the pin.
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        assign pad_io[i]   = pad_oen_i[i] ? 1'bz : pad_out_i[i];
        assign pad_in_w[i] = pad_io[i];
        if (PULLUP_MASK[i]) begin : g_pu
            pullup (pad_io[i]);
        end
        if (PULLDOWN_MASK[i]) begin : g_pd
            pulldown (pad_io[i]);
        end
    end

    (* ASYNC_REG = "TRUE" *)
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= IN_RESET_VAL;
            end
        end else begin
            sync_q[0] <= pad_in_w;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    logic [NUM_PADS-1:0] raw;
    logic [NUM_PADS-1:0] st_q, st_d;
    logic [NUM_PADS-1:0] prev_q;
    logic [FILT_W-1:0]   cnt_q [NUM_PADS];
    logic [FILT_W-1:0]   cnt_d [NUM_PADS];
    logic                thr_zero;
    logic [FILT_W-1:0]   thr_m1;

    assign raw      = sync_q[SYNC_STAGES-1];
    assign thr_zero = (filt_thresh_i == '0);
    // A zero threshold behaves as one sample, which is bypass anyway.
    assign thr_m1   = thr_zero ? '0 : filt_thresh_i - FILT_W'(1);

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            cnt_d[i] = '0;
            if (!filt_en_i[i] || thr_zero) begin
                st_d[i] = raw[i];
            end else if (raw[i] != st_q[i]) begin
                if (cnt_q[i] >= thr_m1) begin
                    st_d[i] = raw[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + FILT_W'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= IN_RESET_VAL;
            prev_q <= IN_RESET_VAL;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q   <= st_d;
            prev_q <= st_q;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pad_in_raw_o = raw;
    assign pad_in_o     = st_q;
    assign rise_o       = st_q & ~prev_q;
    assign fall_o       = ~st_q & prev_q;

endmodule

// File: tb/tb_pad_bank_sync_filter.sv
// Bench for pad_bank_sync_filter: cycle model scoreboard, vector table
// and hand-timed sequences for filter and reset corner cases.
module tb_pad_bank_sync_filter;

    localparam logic [7:0] RV = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] oen, out, fen;
    logic [3:0] thr;
    logic [7:0] drv_en, drv_val;
    logic [7:0] raw_o, in_o, rise_o, fall_o;
    wire  [7:0] pad_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_drv
        assign pad_w[g] = drv_en[g] ? drv_val[g] : 1'bz;
    end

    pad_bank_sync_filter #(
        .NUM_PADS     (8),
        .SYNC_STAGES  (2),
        .FILT_W       (4),
        .PULLUP_MASK  (8'h01),
        .PULLDOWN_MASK(8'h00),
        .IN_RESET_VAL (RV)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pad_oen_i    (oen),
        .pad_out_i    (out),
        .filt_en_i    (fen),
        .filt_thresh_i(thr),
        .pad_in_raw_o (raw_o),
        .pad_in_o     (in_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .pad_io       (pad_w)
    );

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [7:0] in;
        logic [7:0] raw;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] m_s0, m_s1, m_st, m_prev;
    int         m_run [8];

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s0   = RV;
        m_s1   = RV;
        m_st   = RV;
        m_prev = RV;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    // Filter modelled as a run length of consecutive samples disagreeing
    // with the stable state; the state flips when the run reaches T.
    task automatic model_step();
        logic [7:0] smp;
        exp_t       e;
        if (!rst_n) begin
            model_reset();
        end else begin
            smp    = m_s1;
            m_prev = m_st;
            for (int i = 0; i < 8; i++) begin
                if (!fen[i] || thr == 4'd0) begin
                    m_st[i]  = smp[i];
                    m_run[i] = 0;
                end else if (smp[i] == m_st[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] >= int'(thr)) begin
                        m_st[i]  = smp[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_s1 = m_s0;
            m_s0 = pad_w;
        end
        e.in   = m_st;
        e.raw  = m_s1;
        e.rise = m_st & ~m_prev;
        e.fall = ~m_st & m_prev;
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_in", in_o, e.in);
            check("sb_raw", raw_o, e.raw);
            check("sb_rise", rise_o, e.rise);
            check("sb_fall", fall_o, e.fall);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_sb();
        end
    endtask

    typedef struct {
        logic [7:0] drv;
        logic [7:0] fen;
        logic [3:0] thr;
        int         hold;
        logic [7:0] exp_in;
    } vec_t;

    vec_t vecs [7];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{8'h00, 8'h00, 4'd0,  4,  8'h00};
        vecs[1] = '{8'hFF, 8'h00, 4'd0,  3,  8'hFF};
        vecs[2] = '{8'h0F, 8'hFF, 4'd2,  4,  8'h0F};
        vecs[3] = '{8'hF0, 8'hFF, 4'd15, 17, 8'hF0};
        vecs[4] = '{8'h3C, 8'h0F, 4'd5,  3,  8'h30};
        vecs[5] = '{8'h3C, 8'h0F, 4'd5,  4,  8'h3C};
        vecs[6] = '{8'hA5, 8'hFF, 4'd1,  3,  8'hA5};

        // Reset with pad 0 held high
        rst_n   = 1'b0;
        oen     = 8'hFF;
        out     = 8'h00;
        fen     = 8'h00;
        thr     = 4'd0;
        drv_en  = 8'hFF;
        drv_val = 8'h01;
        model_reset();
        tick(3);
        check("rst_in", in_o, 8'h01);
        check("rst_raw", raw_o, 8'h01);
        check("rst_rise", rise_o, 8'h00);
        check("rst_fall", fall_o, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("rel_rise", rise_o, 8'h00);
            check("rel_in", in_o, 8'h01);
        end

        // Bypass step on pad 3
        drv_val = 8'h00;
        tick(4);
        drv_val = 8'h08;
        tick(1);
        check("byp_raw_c1", raw_o & 8'h08, 8'h00);
        tick(1);
        check("byp_raw_c2", raw_o & 8'h08, 8'h08);
        check("byp_in_c2", in_o & 8'h08, 8'h00);
        tick(1);
        check("byp_in_c3", in_o & 8'h08, 8'h08);
        check("byp_rise_c3", rise_o & 8'h08, 8'h08);
        tick(1);
        check("byp_rise_c4", rise_o & 8'h08, 8'h00);

        // Glitch rejection on pad 5, threshold 4
        drv_val = 8'h00;
        tick(4);
        fen     = 8'h20;
        thr     = 4'd4;
        drv_val = 8'h20;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            if (k == 3) drv_val = 8'h00;
            check("glitch_quiet", (in_o | rise_o | fall_o) & 8'h20, 8'h00);
        end

        // Four-cycle pulse passes, fall follows four low samples later
        drv_val = 8'h20;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            if (k == 4) drv_val = 8'h00;
            if (k == 5) check("p4_in_c5", in_o & 8'h20, 8'h00);
            if (k == 6) begin
                check("p4_in_c6", in_o & 8'h20, 8'h20);
                check("p4_rise_c6", rise_o & 8'h20, 8'h20);
            end
            if (k == 7) check("p4_rise_c7", rise_o & 8'h20, 8'h00);
            if (k == 9) check("p4_in_c9", in_o & 8'h20, 8'h20);
            if (k == 10) begin
                check("p4_in_c10", in_o & 8'h20, 8'h00);
                check("p4_fall_c10", fall_o & 8'h20, 8'h20);
            end
            if (k == 11) check("p4_fall_c11", fall_o & 8'h20, 8'h00);
        end

        // Restart: high 3, low 1, high 4
        drv_val = 8'h20;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 3) drv_val = 8'h00;
            if (k == 4) drv_val = 8'h20;
            if (k == 8) drv_val = 8'h00;
            if (k <= 9) check("rst_run_low", in_o & 8'h20, 8'h00);
            if (k == 10) begin
                check("rst_run_in", in_o & 8'h20, 8'h20);
                check("rst_run_rise", rise_o & 8'h20, 8'h20);
            end
        end
        tick(8);

        // Threshold lowered mid-count
        thr     = 4'd8;
        drv_val = 8'h20;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 7) thr = 4'd3;
            if (k <= 7) check("thr_low", in_o & 8'h20, 8'h00);
            if (k == 8) check("thr_flip", in_o & 8'h20, 8'h20);
        end
        drv_val = 8'h00;
        tick(8);
        check("thr_settle", in_o & 8'h20, 8'h00);

        // Filter disabled mid-count
        thr     = 4'd8;
        drv_val = 8'h20;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (k == 4) fen = 8'h00;
            if (k <= 4) check("fen_low", in_o & 8'h20, 8'h00);
            if (k == 5) check("fen_flip", in_o & 8'h20, 8'h20);
        end

        // Vector table
        foreach (vecs[v]) begin
            drv_val = vecs[v].drv;
            fen     = vecs[v].fen;
            thr     = vecs[v].thr;
            tick(vecs[v].hold);
            check($sformatf("vec%0d_in", v), in_o, vecs[v].exp_in);
        end

        // Output path, DUT driving the pins
        drv_en = 8'h00;
        oen    = 8'h00;
        out    = 8'h5A;
        fen    = 8'h00;
        thr    = 4'd0;
        #1;
        check("out_pins_5a", pad_w, 8'h5A);
        tick(2);
        check("out_in_c2", in_o, 8'hA5);
        tick(1);
        check("out_in_c3", in_o, 8'h5A);
        out = 8'hA5;
        #1;
        check("out_pins_a5", pad_w, 8'hA5);
        tick(3);
        check("out_in_a5", in_o, 8'hA5);

        // Asynchronous reset in the middle of a filter count
        fen = 8'hFF;
        thr = 4'd8;
        out = 8'h5A;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in", in_o, RV);
        check("arst_raw", raw_o, RV);
        check("arst_rise", rise_o, 8'h00);
        check("arst_fall", fall_o, 8'h00);
        check("arst_pins", pad_w, 8'h5A);
        model_reset();
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check("arst_recover", in_o, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
